gb_mbc_mapper: RTL and testbench
================================

GB_MBC_MAPPER -- requirements
Module: gb_mbc_mapper

Interface
REQ-001 SHALL have parameter ROM_BANK_W, default 9, width of the 16 KB ROM bank number (512 banks).
REQ-002 SHALL have parameter RAM_BANK_W, default 4, width of the 8 KB RAM bank number (16 banks).
REQ-003 SHALL have port clk_sys, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port ce_cpu, input, 1, CPU clock enable; register writes are qualified by it.
REQ-006 SHALL have port mbc_type, input, 3, mapper mode: 0 none, 1 MBC1, 2 MBC2, 3 MBC3, 4 MBC5, others treated as none.
REQ-007 SHALL have port cart_addr, input, 16, CPU cartridge address.
REQ-008 SHALL have port cart_wr, input, 1, CPU write strobe.
REQ-009 SHALL have port cart_di, input, 8, CPU write data.
REQ-010 SHALL have port rom_mask, input, ROM_BANK_W, mirroring mask for the ROM bank.
REQ-011 SHALL have port ram_mask, input, RAM_BANK_W, mirroring mask for the RAM bank.
REQ-012 SHALL have port rtc_tick, input, 1, one-cycle pulse at 1 Hz.
REQ-013 SHALL have port page, output, ROM_BANK_W+2, 8 KB SDRAM page; MSB=1 selects the RAM region.
REQ-014 SHALL have port ram_en, output, 1, external RAM enabled.
REQ-015 SHALL have port ram_wr, output, 1, qualified cart RAM write.
REQ-016 SHALL have port rtc_sel, output, 1, A000-BFFF currently maps to an RTC register.
REQ-017 SHALL have port rtc_do, output, 8, selected latched RTC register value.

Function
REQ-018 SHALL update control registers only on a cycle with ce_cpu=1, cart_wr=1 and cart_addr[15]=0.
REQ-019 SHALL hold the ram_en register, set by a write with low nibble 0xA and cleared by any other value; regions: 0000-1FFF for MBC1/3/5; 0000-3FFF with A8=0 for MBC2.
REQ-020 SHALL hold all bank and mode registers in MBC1 format: 5-bit bank at 2000-3FFF (0 becomes 1), 2-bit upper at 4000-5FFF, mode bit at 6000-7FFF.
REQ-021 SHALL form the MBC1 ROM bank as {mode?0:upper, bank} and the MBC1 RAM bank as mode?upper:0.
REQ-022 SHALL implement the MBC2 ROM bank as a 4-bit register written in 0000-3FFF with A8=1 (0 becomes 1), with RAM bank always 0.
REQ-023 SHALL implement the MBC3 ROM bank as a 7-bit register at 2000-3FFF (0 becomes 1).
REQ-024 SHALL decode MBC3 writes at 4000-5FFF: values 00-03 select a RAM bank and clear rtc_sel; values 08-0C select an RTC register and set rtc_sel; other values are ignored.
REQ-025 SHALL implement the MBC5 ROM bank as 9 bits: 2000-2FFF writes bits[7:0], 3000-3FFF writes bit 8; bank 0 is permitted.
REQ-026 SHALL implement the MBC5 RAM bank as 4 bits at 4000-5FFF.
REQ-027 SHALL compute page combinationally: 0000-3FFF gives {0,0..0,A13}; 4000-7FFF gives {0,rom_bank&rom_mask,A13}; A000-BFFF gives {1,0..0,ram_bank&ram_mask}; mode none gives {0..0,A14,A13}.
REQ-028 SHALL zero-extend or truncate register fields to ROM_BANK_W/RAM_BANK_W.
REQ-029 SHALL assert ram_wr = ce_cpu & cart_wr & ram_en & A[15:13]=101 & ~rtc_sel.
REQ-030 SHALL apply the last write in each write cycle; a change of mbc_type preserves the registers, and mode none ignores writes.

Reset
REQ-031 SHALL on reset asynchronously set the ROM bank to 1, all other banks to 0, mode, ram_en and rtc_sel to 0, and all RTC counters, latches, halt and carry to 0.
REQ-032 SHALL have page=0, ram_wr=0 and rtc_do=0 when in reset.

Configuration
REQ-033 SHALL, when MBC3_RTC_EN is defined, have running counters sec 0-59, min 0-59, hr 0-23 and day 9-bit, each advancing on rtc_tick when halt=0 and carrying with wrap.
REQ-034 SHALL, when MBC3_RTC_EN is defined, set carry sticky when day wraps 511 to 0.
REQ-035 SHALL, when MBC3_RTC_EN is defined, copy all running counters to the latches on a write of 00 followed by a 01 at 6000-7FFF, with no other write to that range in between.
REQ-036 SHALL, when MBC3_RTC_EN is defined, drive rtc_do from the latch registers 08-0C, with reg 0C = {carry, halt, 00000, day[8]}.
REQ-037 SHALL, when MBC3_RTC_EN is defined, load the selected running counter on a write to A000-BFFF with ram_en=1 and rtc_sel=1.
REQ-038 SHALL, when MBC3_RTC_EN is defined, give a cart write priority over a tick in the same cycle.
REQ-039 SHALL, when MBC3_RTC_EN is undefined, omit all RTC logic, drive rtc_do=8'hFF, and still decode rtc_sel.

Verification
REQ-040 SHALL cover: MBC1, write 0x00 to 2000 -> page at 4000 = {0,bank 1,0}; then write 0x1F, 0x02 to 4000 in mode 0 -> bank 0x5F.
REQ-041 SHALL cover: MBC5, write 0xFF to 2000 and 0x01 to 3000 -> bank 0x1FF; then write 0 -> bank 0; with rom_mask=0x0FF -> 0xFF.
REQ-042 SHALL cover: MBC2, write 0x0A to 0000 -> ram_en=1; write 0x03 to 0100 -> ROM bank 3; write 0x00 to 2100 -> bank 1.
REQ-043 SHALL cover: MBC3 with RTC, set sec=59, min=59, hr=23, day=511, apply 1 tick, latch with 00/01 -> all counters 0, reg 0C reads 0x80.
REQ-044 SHALL cover: ram_en=1, write 0x08 to 4000, write to A000 -> ram_wr=0 and sec loaded; assert reset mid-sequence -> bank 1 and rtc_sel=0 immediately without a clock edge.

Source files
------------

// File: rtl/gb_mbc_mapper.sv
// gb_mbc_mapper: Game Boy cartridge mapper (none/MBC1/MBC2/MBC3/MBC5) to SDRAM pages.
// Define MBC3_RTC_EN to build the MBC3 real-time clock; otherwise rtc_do reads 8'hFF.
module gb_mbc_mapper #(
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce_cpu,
  input  logic [2:0]            mbc_type,
  input  logic [15:0]           cart_addr,
  input  logic                  cart_wr,
  input  logic [7:0]            cart_di,
  input  logic [ROM_BANK_W-1:0] rom_mask,
  input  logic [RAM_BANK_W-1:0] ram_mask,
  input  logic                  rtc_tick,
  output logic [ROM_BANK_W+1:0] page,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic                  rtc_sel,
  output logic [7:0]            rtc_do
);

  localparam logic [2:0] MBC1 = 3'd1;
  localparam logic [2:0] MBC2 = 3'd2;
  localparam logic [2:0] MBC3 = 3'd3;
  localparam logic [2:0] MBC5 = 3'd4;

  logic is_m1, is_m2, is_m3, is_m5, is_map;
  logic [1:0] zone;
  logic ctl_wr, ram_area, ram_en_hit, m2_bank_hit;

  assign is_m1  = mbc_type == MBC1;
  assign is_m2  = mbc_type == MBC2;
  assign is_m3  = mbc_type == MBC3;
  assign is_m5  = mbc_type == MBC5;
  assign is_map = is_m1 | is_m2 | is_m3 | is_m5;

  assign zone     = cart_addr[14:13];
  assign ctl_wr   = ce_cpu & cart_wr & ~cart_addr[15] & is_map;
  assign ram_area = cart_addr[15:13] == 3'b101;

  // MBC2 splits 0000-3FFF on A8 instead of on A13
  assign ram_en_hit  = is_m2 ? (~cart_addr[14] & ~cart_addr[8])
                             : (zone == 2'b00);
  assign m2_bank_hit = is_m2 & ~cart_addr[14] & cart_addr[8];

  logic       ram_en_q;
  logic       sel_q;
  logic [4:0] m1_bank;
  logic [1:0] m1_upper;
  logic       m1_mode;
  logic [3:0] m2_bank;
  logic [6:0] m3_bank;
  logic [1:0] m3_ram;
  logic [2:0] rtc_idx;
  logic [8:0] m5_bank;
  logic [3:0] m5_ram;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ram_en_q <= 1'b0;
      sel_q    <= 1'b0;
      m1_bank  <= 5'd1;
      m1_upper <= 2'd0;
      m1_mode  <= 1'b0;
      m2_bank  <= 4'd1;
      m3_bank  <= 7'd1;
      m3_ram   <= 2'd0;
      rtc_idx  <= 3'd0;
      m5_bank  <= 9'd1;
      m5_ram   <= 4'd0;
    end else if (ctl_wr) begin
      if (ram_en_hit)
        ram_en_q <= cart_di[3:0] == 4'hA;
      unique case (1'b1)
        is_m1: begin
          case (zone)
            2'b01: m1_bank <= (cart_di[4:0] == 5'd0) ? 5'd1
                                                     : cart_di[4:0];
            2'b10: m1_upper <= cart_di[1:0];
            2'b11: m1_mode <= cart_di[0];
            default: ;
          endcase
        end
        is_m2: begin
          if (m2_bank_hit)
            m2_bank <= (cart_di[3:0] == 4'd0) ? 4'd1
                                              : cart_di[3:0];
        end
        is_m3: begin
          case (zone)
            2'b01: m3_bank <= (cart_di[6:0] == 7'd0) ? 7'd1
                                                     : cart_di[6:0];
            2'b10: begin
              if (cart_di <= 8'h03) begin
                m3_ram <= cart_di[1:0];
                sel_q  <= 1'b0;
              end else if (cart_di >= 8'h08 && cart_di <= 8'h0C) begin
                rtc_idx <= cart_di[2:0] - 3'd0;
                sel_q   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        is_m5: begin
          case (zone)
            2'b01: begin
              if (cart_addr[12])
                m5_bank[8] <= cart_di[0];
              else
                m5_bank[7:0] <= cart_di;
            end
            2'b10: m5_ram <= cart_di[3:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  logic [8:0]            rom_raw;
  logic [3:0]            ram_raw;
  logic [ROM_BANK_W-1:0] rom_b;
  logic [RAM_BANK_W-1:0] ram_b;

  always_comb begin
    rom_raw = 9'd0;
    ram_raw = 4'd0;
    unique case (1'b1)
      is_m1: begin
        rom_raw = {2'b00, (m1_mode ? 2'b00 : m1_upper), m1_bank};
        ram_raw = {2'b00, (m1_mode ? m1_upper : 2'b00)};
      end
      is_m2: rom_raw = {5'd0, m2_bank};
      is_m3: begin
        rom_raw = {2'd0, m3_bank};
        ram_raw = {2'd0, m3_ram};
      end
      is_m5: begin
        rom_raw = m5_bank;
        ram_raw = m5_ram;
      end
      default: ;
    endcase
  end

  assign rom_b = ROM_BANK_W'(rom_raw);
  assign ram_b = RAM_BANK_W'(ram_raw);

  logic [ROM_BANK_W+1:0] page_c;

  always_comb begin
    page_c = '0;
    if (!is_map)
      page_c = {{ROM_BANK_W{1'b0}}, cart_addr[14:13]};
    else if (cart_addr[15:14] == 2'b00)
      page_c = {1'b0, {ROM_BANK_W{1'b0}}, cart_addr[13]};
    else if (cart_addr[15:14] == 2'b01)
      page_c = {1'b0, rom_b & rom_mask, cart_addr[13]};
    else if (ram_area)
      page_c = {1'b1, {(ROM_BANK_W+1-RAM_BANK_W){1'b0}},
                ram_b & ram_mask};
  end

  assign page    = reset ? '0 : page_c;
  assign ram_en  = ram_en_q;
  assign rtc_sel = sel_q;
  assign ram_wr  = ce_cpu & cart_wr & ram_en_q & ram_area & ~sel_q;

`ifdef MBC3_RTC_EN
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic [8:0] day;
  logic       halt, carry;
  logic [5:0] l_sec, l_min;
  logic [4:0] l_hr;
  logic [8:0] l_day;
  logic       l_halt, l_carry;
  logic       armed, latch_wr, do_latch;
  logic       rtc_load, adv, sec_w, min_w, hr_w;
  logic [7:0] rtc_val;

  assign rtc_load = ce_cpu & cart_wr & ram_area & ram_en_q & sel_q;
  assign adv      = rtc_tick & ~halt & ~rtc_load;
  assign sec_w    = sec >= 6'd59;
  assign min_w    = min >= 6'd59;
  assign hr_w     = hr >= 5'd23;
  assign latch_wr = ctl_wr & is_m3 & (zone == 2'b11);
  assign do_latch = latch_wr & armed & (cart_di == 8'h01);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sec   <= 6'd0;
      min   <= 6'd0;
      hr    <= 5'd0;
      day   <= 9'd0;
      halt  <= 1'b0;
      carry <= 1'b0;
    end else if (rtc_load) begin
      case (rtc_idx)
        3'd0: sec <= cart_di[5:0];
        3'd1: min <= cart_di[5:0];
        3'd2: hr <= cart_di[4:0];
        3'd3: day[7:0] <= cart_di;
        3'd4: begin
          day[8] <= cart_di[0];
          halt   <= cart_di[6];
          carry  <= cart_di[7];
        end
        default: ;
      endcase
    end else if (adv) begin
      sec <= sec_w ? 6'd0 : sec + 6'd1;
      if (sec_w)
        min <= min_w ? 6'd0 : min + 6'd1;
      if (sec_w & min_w)
        hr <= hr_w ? 5'd0 : hr + 5'd1;
      if (sec_w & min_w & hr_w) begin
        day <= day + 9'd1;
        if (day == 9'd511)
          carry <= 1'b1;
      end
    end
  end

  // latch fires only on 00 immediately followed by 01 in 6000-7FFF
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      l_sec   <= 6'd0;
      l_min   <= 6'd0;
      l_hr    <= 5'd0;
      l_day   <= 9'd0;
      l_halt  <= 1'b0;
      l_carry <= 1'b0;
    end else if (latch_wr) begin
      armed <= cart_di == 8'h00;
      if (do_latch) begin
        l_sec   <= sec;
        l_min   <= min;
        l_hr    <= hr;
        l_day   <= day;
        l_halt  <= halt;
        l_carry <= carry;
      end
    end
  end

  always_comb begin
    rtc_val = 8'hFF;
    case (rtc_idx)
      3'd0: rtc_val = {2'b00, l_sec};
      3'd1: rtc_val = {2'b00, l_min};
      3'd2: rtc_val = {3'b000, l_hr};
      3'd3: rtc_val = l_day[7:0];
      3'd4: rtc_val = {l_carry, l_halt, 5'b00000, l_day[8]};
      default: rtc_val = 8'hFF;
    endcase
  end

  assign rtc_do = reset ? 8'h00 : rtc_val;

  logic addr_unused;
  assign addr_unused = ^{cart_addr[11:9], cart_addr[7:0]};
`else
  assign rtc_do = reset ? 8'h00 : 8'hFF;

  logic rtc_unused;
  assign rtc_unused = ^{rtc_tick, rtc_idx,
                        cart_addr[11:9], cart_addr[7:0]};
`endif

endmodule

// File: tb/tb_gb_mbc_mapper.sv
// tb_gb_mbc_mapper: directed and random checks of gb_mbc_mapper
// against a behavioural model of the mapper register rules.
module tb_gb_mbc_mapper;

  localparam int RW = 9;
  localparam int AW = 4;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ce_cpu;
  logic [2:0]    mbc_type;
  logic [15:0]   cart_addr;
  logic          cart_wr;
  logic [7:0]    cart_di;
  logic [RW-1:0] rom_mask;
  logic [AW-1:0] ram_mask;
  logic          rtc_tick;
  logic [RW+1:0] page;
  logic          ram_en;
  logic          ram_wr;
  logic          rtc_sel;
  logic [7:0]    rtc_do;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_sys = ~clk_sys;

  gb_mbc_mapper #(.ROM_BANK_W(RW), .RAM_BANK_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu),
    .mbc_type(mbc_type), .cart_addr(cart_addr), .cart_wr(cart_wr),
    .cart_di(cart_di), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .rtc_tick(rtc_tick), .page(page), .ram_en(ram_en),
    .ram_wr(ram_wr), .rtc_sel(rtc_sel), .rtc_do(rtc_do)
  );

  // behavioural model state
  int m_ren, m_b1, m_up, m_mode, m_b2, m_b3, m_r3, m_sel, m_idx;
  int m_b5, m_r5, m_last6;
  int m_sec, m_min, m_hr, m_day, m_halt, m_carry;
  int l_sec, l_min, l_hr, l_day, l_halt, l_carry;

  task automatic model_reset();
    m_ren = 0; m_b1 = 1; m_up = 0; m_mode = 0; m_b2 = 1; m_b3 = 1;
    m_r3 = 0; m_sel = 0; m_idx = 0; m_b5 = 1; m_r5 = 0; m_last6 = -1;
    m_sec = 0; m_min = 0; m_hr = 0; m_day = 0; m_halt = 0; m_carry = 0;
    l_sec = 0; l_min = 0; l_hr = 0; l_day = 0; l_halt = 0; l_carry = 0;
  endtask

  function automatic int rom_bank(int t);
    case (t)
      1: return (m_mode ? 0 : m_up) * 32 + m_b1;
      2: return m_b2;
      3: return m_b3;
      4: return m_b5;
      default: return 0;
    endcase
  endfunction

  function automatic int ram_bank(int t);
    case (t)
      1: return m_mode ? m_up : 0;
      3: return m_r3;
      4: return m_r5;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_page();
    int a, t, a13;
    a = int'(cart_addr);
    t = int'(mbc_type);
    a13 = (a >> 13) & 1;
    if (t < 1 || t > 4) return (a >> 13) & 3;
    if (a < 'h4000) return a13;
    if (a < 'h8000) return ((rom_bank(t) & int'(rom_mask)) << 1) | a13;
    if (a >= 'hA000 && a < 'hC000)
      return (1 << (RW + 1)) | (ram_bank(t) & int'(ram_mask));
    return 0;
  endfunction

  function automatic int exp_ram_wr();
    return (ce_cpu && cart_wr && m_ren != 0 &&
            (int'(cart_addr) >> 13) == 5 && m_sel == 0) ? 1 : 0;
  endfunction

  function automatic int exp_rtc_do();
`ifdef MBC3_RTC_EN
    case (m_idx)
      0: return l_sec;
      1: return l_min;
      2: return l_hr;
      3: return l_day % 256;
      default: return l_carry * 128 + l_halt * 64 + l_day / 256;
    endcase
`else
    return 255;
`endif
  endfunction

  task automatic model_apply();
    int a, d, t;
    bit w, loaded;
    a = int'(cart_addr);
    d = int'(cart_di);
    t = int'(mbc_type);
    w = ce_cpu && cart_wr;
    loaded = 0;
    if (w && a < 'h8000 && t >= 1 && t <= 4) begin
      if (t == 2) begin
        if (a < 'h4000) begin
          if ((a & 'h100) != 0) m_b2 = (d % 16 == 0) ? 1 : d % 16;
          else m_ren = (d % 16 == 10);
        end
      end else if (a < 'h2000) begin
        m_ren = (d % 16 == 10);
      end else if (t == 1) begin
        if (a < 'h4000) m_b1 = (d % 32 == 0) ? 1 : d % 32;
        else if (a < 'h6000) m_up = d % 4;
        else m_mode = d % 2;
      end else if (t == 3) begin
        if (a < 'h4000) m_b3 = (d % 128 == 0) ? 1 : d % 128;
        else if (a < 'h6000) begin
          if (d <= 3) begin m_r3 = d; m_sel = 0; end
          else if (d >= 8 && d <= 12) begin m_idx = d - 8; m_sel = 1; end
        end else begin
          if (d == 1 && m_last6 == 0) begin
            l_sec = m_sec; l_min = m_min; l_hr = m_hr;
            l_day = m_day; l_halt = m_halt; l_carry = m_carry;
          end
          m_last6 = d;
        end
      end else begin
        if (a < 'h3000) m_b5 = (m_b5 & 256) | d;
        else if (a < 'h4000) m_b5 = (m_b5 & 255) | (d % 2) * 256;
        else if (a < 'h6000) m_r5 = d % 16;
      end
    end
`ifdef MBC3_RTC_EN
    if (w && a >= 'hA000 && a < 'hC000 && m_ren != 0 && m_sel != 0) begin
      loaded = 1;
      case (m_idx)
        0: m_sec = d % 64;
        1: m_min = d % 64;
        2: m_hr = d % 32;
        3: m_day = (m_day / 256) * 256 + d;
        default: begin
          m_day = m_day % 256 + (d % 2) * 256;
          m_halt = (d >> 6) & 1;
          m_carry = (d >> 7) & 1;
        end
      endcase
    end
    if (rtc_tick && m_halt == 0 && !loaded) begin
      m_sec++;
      if (m_sec >= 60) begin
        m_sec = 0; m_min++;
        if (m_min >= 60) begin
          m_min = 0; m_hr++;
          if (m_hr >= 24) begin
            m_hr = 0; m_day++;
            if (m_day == 512) begin m_day = 0; m_carry = 1; end
          end
        end
      end
    end
`endif
  endtask

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("page", int'(page), exp_page());
    check("ram_en", int'(ram_en), m_ren);
    check("ram_wr", int'(ram_wr), exp_ram_wr());
    check("rtc_sel", int'(rtc_sel), m_sel);
    check("rtc_do", int'(rtc_do), exp_rtc_do());
  endtask

  // entered just after a rising edge; leaves just after the next one
  task automatic step(input logic [2:0] t, input logic [15:0] a,
                      input logic w, input logic [7:0] d,
                      input logic c, input logic tk);
    mbc_type = t; cart_addr = a; cart_wr = w;
    cart_di = d; ce_cpu = c; rtc_tick = tk;
    #2;
    compare_all();
    @(posedge clk_sys);
    model_apply();
    #1;
  endtask

  task automatic wr(input logic [2:0] t, input logic [15:0] a,
                    input logic [7:0] d);
    step(t, a, 1'b1, d, 1'b1, 1'b0);
  endtask

  task automatic peek(input logic [15:0] a);
    cart_addr = a; cart_wr = 1'b0; rtc_tick = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] sp [12];
    sp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h08,
           8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h3B, 8'hFF};
    if ($urandom_range(0, 1) == 0) return sp[$urandom_range(0, 11)];
    return 8'($urandom);
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0)
      return 16'hA000 | 16'($urandom_range(0, 'h1FFF));
    return 16'($urandom);
  endfunction

  initial begin
    logic [RW-1:0] masks [4];
    logic [2:0] t;
    masks = '{9'h1FF, 9'h0FF, 9'h07F, 9'h01F};
    model_reset();
    reset = 1'b1; ce_cpu = 1'b0; cart_wr = 1'b0; rtc_tick = 1'b0;
    mbc_type = 3'd1; cart_addr = 16'h6000; cart_di = 8'h00;
    rom_mask = 9'h1FF; ram_mask = 4'hF;
    #2;
    check("rst_page", int'(page), 0);
    check("rst_ram_wr", int'(ram_wr), 0);
    check("rst_rtc_do", int'(rtc_do), 0);
    check("rst_ram_en", int'(ram_en), 0);
    check("rst_rtc_sel", int'(rtc_sel), 0);
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset = 1'b0;
    #1;
    check("rst_bank1_page", int'(page), 'h003);

    // MBC1: bank 0 maps to 1, then upper bits join in mode 0
    wr(3'd1, 16'h2000, 8'h00);
    peek(16'h4000);
    check("m1_bank1", int'(page), 'h002);
    wr(3'd1, 16'h2000, 8'h1F);
    wr(3'd1, 16'h4000, 8'h02);
    peek(16'h4000);
    check("m1_bank5f", int'(page), 'h0BE);
    check("model_m1_bank5f", exp_page(), 'h0BE);
    wr(3'd1, 16'h6000, 8'h01);
    peek(16'hA000);
    check("m1_mode1_ram", int'(page), 'h402);

    // MBC5: full 9-bit bank, mask, and bank 0
    wr(3'd4, 16'h2000, 8'hFF);
    wr(3'd4, 16'h3000, 8'h01);
    peek(16'h4000);
    check("m5_bank1ff", int'(page), 'h3FE);
    check("model_m5_bank1ff", exp_page(), 'h3FE);
    rom_mask = 9'h0FF;
    #1;
    check("m5_mask_ff", int'(page), 'h1FE);
    rom_mask = 9'h1FF;
    wr(3'd4, 16'h2000, 8'h00);
    wr(3'd4, 16'h3000, 8'h00);
    peek(16'h6000);
    check("m5_bank0", int'(page), 'h001);

    // MBC2: A8 splits RAM enable and ROM bank
    wr(3'd2, 16'h0000, 8'h0A);
    check("m2_ram_en", int'(ram_en), 1);
    wr(3'd2, 16'h0100, 8'h03);
    peek(16'h4000);
    check("m2_bank3", int'(page), 'h006);
    wr(3'd2, 16'h2100, 8'h00);
    peek(16'h4000);
    check("m2_bank1", int'(page), 'h002);
    check("m2_ram_en_kept", int'(ram_en), 1);

    // MBC3 RTC: full rollover into the day carry
    wr(3'd3, 16'h0000, 8'h0A);
`ifdef MBC3_RTC_EN
    wr(3'd3, 16'h4000, 8'h08); wr(3'd3, 16'hA000, 8'd59);
    wr(3'd3, 16'h4000, 8'h09); wr(3'd3, 16'hA000, 8'd59);
    wr(3'd3, 16'h4000, 8'h0A); wr(3'd3, 16'hA000, 8'd23);
    wr(3'd3, 16'h4000, 8'h0B); wr(3'd3, 16'hA000, 8'hFF);
    wr(3'd3, 16'h4000, 8'h0C); wr(3'd3, 16'hA000, 8'h01);
    step(3'd3, 16'h4000, 1'b0, 8'h00, 1'b1, 1'b1);
    wr(3'd3, 16'h6000, 8'h00);
    wr(3'd3, 16'h6000, 8'h01);
    for (int r = 8; r <= 12; r++) begin
      wr(3'd3, 16'h4000, 8'(r));
      check("rtc_roll", int'(rtc_do), (r == 12) ? 'h80 : 0);
    end
`else
    wr(3'd3, 16'h4000, 8'h08);
    check("rtc_off_do", int'(rtc_do), 'hFF);
`endif

    // RTC selected: A000 write is not a RAM write
    wr(3'd3, 16'h4000, 8'h08);
    check("rtc_sel_set", int'(rtc_sel), 1);
    mbc_type = 3'd3; cart_addr = 16'hA000; cart_wr = 1'b1;
    cart_di = 8'h2A; ce_cpu = 1'b1; rtc_tick = 1'b0;
    #1;
    check("rtc_no_ram_wr", int'(ram_wr), 0);
    @(posedge clk_sys);
    model_apply();
    #1;
`ifdef MBC3_RTC_EN
    wr(3'd3, 16'h6000, 8'h00);
    wr(3'd3, 16'h6000, 8'h01);
    check("rtc_sec_loaded", int'(rtc_do), 'h2A);
`endif
    wr(3'd3, 16'h4000, 8'h01);
    cart_addr = 16'hA000; cart_wr = 1'b1; ce_cpu = 1'b1;
    #1;
    check("ram_wr_bank", int'(ram_wr), 1);
    @(posedge clk_sys);
    model_apply();
    #1;
    wr(3'd3, 16'h2000, 8'h05);
    wr(3'd3, 16'h4000, 8'h09);

    // asynchronous reset between clock edges
    ce_cpu = 1'b0; cart_wr = 1'b0; cart_addr = 16'h4000;
    reset = 1'b1;
    #1;
    check("arst_rtc_sel", int'(rtc_sel), 0);
    check("arst_page", int'(page), 0);
    check("arst_ram_en", int'(ram_en), 0);
    check("arst_rtc_do", int'(rtc_do), 0);
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_bank1", int'(page), 'h002);

    // random traffic against the model
    t = 3'd1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        t = ($urandom_range(0, 5) == 5) ? 3'($urandom) :
            3'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 63) == 0) begin
        rom_mask = ($urandom_range(0, 4) == 4) ? 9'($urandom) :
                   masks[$urandom_range(0, 3)];
        ram_mask = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      end
      step(t, rand_addr(), 1'($urandom_range(0, 1)), rand_data(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
